fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//  Downstream consumer of the generic fifo. Pops DATA_W words via fifo_rd_en/fifo_rdata,
//  packs PACK_RATIO words into one PACK_RATIO*DATA_W beat and presents it on a valid/ready
//  stream. A flush request emits any partial word tagged last. It also owns the fifo soft init.
// PARAMETERS
//  DATA_W      8   fifo word width
//  PACK_RATIO  4   fifo words per output beat (>=2)
//  CNT_W       $clog2(PACK_RATIO+1)  localparam, width of out_cnt
// PORTS
//  clk         in   1                  clock
//  rst_n       in   1                  synchronous active-low reset
//  init        in   1                  soft clear of packer; forwarded to fifo
//  fifo_init   out  1                  = init (combinational pass-through)
//  fifo_empty  in   1                  fifo empty flag
//  fifo_rd_en  out  1                  pop request to fifo
//  fifo_rdata  in   DATA_W             fifo read data, valid the cycle after fifo_rd_en
//  flush_req   in   1                  1-cycle pulse: emit residue
//  flush_done  out  1                  1-cycle pulse: flush complete
//  out_valid   out  1                  output beat valid
//  out_ready   in   1                  downstream accept
//  out_data    out  PACK_RATIO*DATA_W  packed beat; first-popped word in [DATA_W-1:0]
//  out_cnt     out  CNT_W              valid lanes in beat (PACK_RATIO for full beats)
//  out_last    out  1                  beat closes a flush
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge) or init=1: all outputs 0; cnt=0, rd_pend=0, FSM=RUN.
//    An in-flight pop is discarded (that word is lost). init has priority over flush.
//  - State: acc (PACK_RATIO lanes), cnt (lanes landed, 0..PACK_RATIO), rd_pend (pop in
//    flight, 0/1), output reg {out_data,out_cnt,out_last,out_valid}.
//  - Read latency fixed at 1: pop at cycle t -> fifo_rdata sampled into lane cnt at t+1.
//  - out_free = !out_valid || out_ready. land = rd_pend. complete = land && cnt==PACK_RATIO-1.
//  - fifo_rd_en = FSM==RUN && !flush_req && !fifo_empty &&
//      ((cnt+rd_pend < PACK_RATIO) || (complete && out_free)). Never pops when empty.
//  - On complete: if out_free, beat loads output reg same edge (out_cnt=PACK_RATIO,
//    out_last=0), cnt->0; else acc holds with cnt=PACK_RATIO until out_free, then loads.
//  - Sustained throughput 1 pop/cycle with out_ready=1 and fifo non-empty; first beat
//    out_valid PACK_RATIO+1 cycles after first fifo_rd_en.
//  - Output stable while out_valid && !out_ready; transfer when out_valid && out_ready.
//  - FSM: RUN -> DRAIN on flush_req (no new pops from that cycle).
//    DRAIN: wait rd_pend=0 and any full acc moved out -> EMIT.
//    EMIT: if cnt>0, when out_free load acc zero-padded above cnt lanes, out_cnt=cnt,
//      out_last=1, cnt->0, -> DONE; if cnt==0 -> DONE immediately (no last beat).
//    DONE: wait out_valid=0 (last beat taken) -> flush_done=1 one cycle, -> RUN.
//  - flush_req outside RUN is ignored. Simultaneous pop landing and flush_req: word lands.
//  - All arithmetic unsigned; cnt+rd_pend evaluated in CNT_W+1 bits; no wrap.
// TESTING
//  1. Reset: rst_n=0 2 cycles with fifo non-empty -> all outputs 0, no fifo_rd_en.
//  2. Push 8 words 0x11..0x88, out_ready=1 -> beats 0x44332211, 0x88776655, out_cnt=4,
//     out_last=0, 8 consecutive fifo_rd_en cycles, no pop after empty.
//  3. Same 8 words, out_ready=0 for 20 cycles -> first beat held stable, exactly 8 pops
//     (acc fills, stalls), then out_ready=1 delivers both beats in order.
//  4. Push 0xA1,0xB2,0xC3, flush_req after 3rd lands -> beat 0x00C3B2A1, out_cnt=3,
//     out_last=1, then flush_done pulse; flush with cnt=0 -> flush_done only, no beat.
//  5. flush_req in same cycle a pop is in flight -> word lands, included in partial beat.
//  6. init mid-accumulation (cnt=2) -> fifo_init=1 same cycle, out_valid=0, cnt=0; next
//     4 words form a clean beat.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side consumer of a generic fifo. Pops DATA_W-bit words from the fifo (one-cycle read
//   latency), packs PACK_RATIO of them into a single beat and presents the beat on a
//   valid/ready stream. A flush request emits any partially filled beat, tagged last, and
//   then pulses flush_done. The soft init is forwarded to the fifo and clears the packer.
//
// Ports
//   clk, rst_n   clock and synchronous active-low reset
//   init         soft clear of the packer, forwarded combinationally on fifo_init
//   fifo_empty   fifo empty flag
//   fifo_rd_en   pop request to the fifo
//   fifo_rdata   fifo read data, valid the cycle after fifo_rd_en
//   flush_req    single-cycle request to emit the residue
//   flush_done   single-cycle pulse once the flush has completed
//   out_valid    output beat valid
//   out_ready    downstream accept
//   out_data     packed beat, first-popped word in the lowest lane
//   out_cnt      number of valid lanes in the beat
//   out_last     beat closes a flush
module fifo_rd_packer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PACK_RATIO = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              init,
  output logic                              fifo_init,
  input  logic                              fifo_empty,
  output logic                              fifo_rd_en,
  input  logic [DATA_W-1:0]                 fifo_rdata,
  input  logic                              flush_req,
  output logic                              flush_done,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PACK_RATIO*DATA_W-1:0]      out_data,
  output logic [$clog2(PACK_RATIO+1)-1:0]   out_cnt,
  output logic                              out_last
);

  localparam int unsigned CNT_W  = $clog2(PACK_RATIO + 1);
  localparam int unsigned BEAT_W = PACK_RATIO * DATA_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK_RATIO - 1);
  localparam logic [CNT_W:0]   FULL_CNT_X = (CNT_W + 1)'(PACK_RATIO);

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StEmit,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic [BEAT_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                out_last_q, out_last_d;
  logic                out_valid_q, out_valid_d;
  logic                flush_done_q, flush_done_d;

  logic                out_free;
  logic                land;
  logic                complete;
  logic                room;
  logic [BEAT_W-1:0]   acc_land;
  logic [BEAT_W-1:0]   pad_beat;

  assign out_free = !out_valid_q || out_ready;
  assign land     = rd_pend_q;
  assign complete = land && (cnt_q == LAST_LANE);

  // A pop is allowed while the lanes already landed plus the one in flight leave space, or
  // when the landing word completes a beat that can leave this very edge.
  assign room = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, rd_pend_q}) < FULL_CNT_X;

  assign fifo_rd_en = rst_n && !init && (state_q == StRun) && !flush_req && !fifo_empty &&
                      (room || (complete && out_free));

  // Accumulator with the landing word written into lane cnt.
  always_comb begin
    acc_land = acc_q;
    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        acc_land[i*DATA_W +: DATA_W] = fifo_rdata;
      end
    end
  end

  // Partial beat: lanes at or above cnt are forced to zero.
  always_comb begin
    pad_beat = '0;
    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
      if (CNT_W'(i) < cnt_q) begin
        pad_beat[i*DATA_W +: DATA_W] = acc_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: datapath, output register and flush FSM.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    rd_pend_d    = fifo_rd_en;
    out_data_d   = out_data_q;
    out_cnt_d    = out_cnt_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q && !out_ready;
    flush_done_d = 1'b0;

    if (land) begin
      acc_d = acc_land;
      if (complete) begin
        if (out_free) begin
          out_data_d  = acc_land;
          out_cnt_d   = FULL_CNT;
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          // Beat parked in the accumulator until the output register frees up.
          cnt_d = FULL_CNT;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (cnt_q == FULL_CNT) begin
      if (out_free) begin
        out_data_d  = acc_q;
        out_cnt_d   = FULL_CNT;
        out_last_d  = 1'b0;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end
    end else if ((state_q == StEmit) && (cnt_q != '0) && out_free) begin
      out_data_d  = pad_beat;
      out_cnt_d   = cnt_q;
      out_last_d  = 1'b1;
      out_valid_d = 1'b1;
      cnt_d       = '0;
    end

    unique case (state_q)
      StRun: begin
        if (flush_req) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Wait for the last pop to land and any parked full beat to leave.
        if (!rd_pend_q && (cnt_q != FULL_CNT)) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if ((cnt_q == '0) || out_free) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!out_valid_q) begin
          flush_done_d = 1'b1;
          state_d      = StRun;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      state_q      <= StRun;
      acc_q        <= '0;
      cnt_q        <= '0;
      rd_pend_q    <= 1'b0;
      out_data_q   <= '0;
      out_cnt_q    <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      rd_pend_q    <= rd_pend_d;
      out_data_q   <= out_data_d;
      out_cnt_q    <= out_cnt_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign fifo_init  = init;
  assign flush_done = flush_done_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_cnt    = out_cnt_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-backed fifo with one-cycle read latency feeds the DUT,
// and a word-level packing model predicts every output beat.
module tb_fifo_rd_packer;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PACK_RATIO = 4;
  localparam int unsigned CNT_W      = $clog2(PACK_RATIO + 1);
  localparam int unsigned BEAT_W     = PACK_RATIO * DATA_W;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                init;
  logic                fifo_init;
  logic                fifo_empty;
  logic                fifo_rd_en;
  logic [DATA_W-1:0]   fifo_rdata;
  logic                flush_req;
  logic                flush_done;
  logic                out_valid;
  logic                out_ready;
  logic [BEAT_W-1:0]   out_data;
  logic [CNT_W-1:0]    out_cnt;
  logic                out_last;

  always #5 clk = ~clk;

  fifo_rd_packer #(
    .DATA_W     (DATA_W),
    .PACK_RATIO (PACK_RATIO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .fifo_init  (fifo_init),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_cnt    (out_cnt),
    .out_last   (out_last)
  );

  // Fifo: stimulus owns wr_ptr/mem, the read process owns rd_ptr.
  logic [DATA_W-1:0] mem [0:1023];
  int                wr_ptr = 0;
  int                rd_ptr = 0;
  logic [DATA_W-1:0] rdata_r;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = rdata_r;

  always @(posedge clk) begin
    if (!fifo_init && fifo_rd_en && (rd_ptr != wr_ptr)) begin
      rdata_r <= mem[rd_ptr[9:0]];
      rd_ptr  <= rd_ptr + 1;
    end else begin
      // Garbage outside the valid cycle exposes mistimed sampling.
      rdata_r <= DATA_W'($urandom);
      if (fifo_init) rd_ptr <= wr_ptr;
    end
  end

  typedef struct {
    logic [BEAT_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
    logic              last;
  } beat_t;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] lanes[$];

  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          rd_cnt, first_rd, last_rd, first_vld;
  int          fd_cnt = 0;
  bit          stall_prev = 1'b0;
  bit          rand_ready = 1'b0;
  logic [63:0] prev_bundle;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: words land in order; every PACK_RATIO words make a full beat.
  task automatic emit_lanes(input bit last);
    beat_t b;
    b.data = '0;
    for (int i = 0; i < lanes.size(); i++) b.data[i*DATA_W +: DATA_W] = lanes[i];
    b.cnt  = CNT_W'(lanes.size());
    b.last = last;
    exp_q.push_back(b);
    lanes.delete();
  endtask

  task automatic send(input logic [DATA_W-1:0] w);
    mem[wr_ptr[9:0]] = w;
    wr_ptr++;
    lanes.push_back(w);
    if (lanes.size() == PACK_RATIO) emit_lanes(1'b0);
  endtask

  task automatic model_flush();
    if (lanes.size() > 0) emit_lanes(1'b1);
  endtask

  task automatic clear_stats();
    rd_cnt = 0;
    first_rd = -1;
    last_rd = -1;
    first_vld = -1;
  endtask

  // One clock cycle: per-cycle checks mid-cycle, then advance to just after the next edge.
  task automatic tick();
    beat_t e;
    #3;
    if (rst_n && !init) begin
      if (fifo_rd_en) begin
        check("pop_when_empty", 64'(fifo_empty), 64'(0));
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (stall_prev) begin
        check("stall_stable", 64'({out_valid, out_last, out_cnt, out_data}), prev_bundle);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          e.data = 'x;
          e.cnt  = 'x;
          e.last = 1'bx;
        end else begin
          e = exp_q.pop_front();
        end
        check("beat", 64'({out_last, out_cnt, out_data}), 64'({e.last, e.cnt, e.data}));
      end
      if (flush_done) fd_cnt++;
      stall_prev  = out_valid && !out_ready;
      prev_bundle = 64'({out_valid, out_last, out_cnt, out_data});
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    cyc++;
  endtask

  task automatic wait_popped(input int bound);
    int n = 0;
    while (rd_ptr != wr_ptr && n < bound) begin
      tick();
      n++;
    end
    check("pop_timeout", 64'(rd_ptr), 64'(wr_ptr));
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_fd(input int target, input int bound);
    int n = 0;
    while (fd_cnt < target && n < bound) begin
      tick();
      n++;
    end
    check("flush_done_count", 64'(fd_cnt), 64'(target));
  endtask

  task automatic flush_pulse();
    flush_req = 1'b1;
    model_flush();
    tick();
    flush_req = 1'b0;
  endtask

  initial begin
    int fd0;
    int n;
    rst_n = 1'b0;
    init = 1'b0;
    flush_req = 1'b0;
    out_ready = 1'b1;
    clear_stats();

    // Reset with a non-empty fifo: nothing may move.
    for (int i = 1; i <= 8; i++) send(DATA_W'(8'h11 * i));
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_outputs", 64'({fifo_rd_en, fifo_init, flush_done, out_valid, out_last,
                                  out_cnt, out_data}), 64'(0));
    end
    check("reset_no_pop", 64'(rd_ptr), 64'(0));

    // Streaming with out_ready held high.
    rst_n = 1'b1;
    clear_stats();
    drain(60);
    repeat (4) tick();
    check("t2_pops", 64'(rd_cnt), 64'(8));
    check("t2_consecutive", 64'(last_rd - first_rd), 64'(7));
    check("t2_latency", 64'(first_vld - first_rd), 64'(PACK_RATIO + 1));

    // Back-pressure: first beat held, accumulator fills, pops stop at 8.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(DATA_W'(8'h11 * i));
    clear_stats();
    repeat (20) tick();
    check("t3_pops", 64'(rd_cnt), 64'(8));
    check("t3_held_valid", 64'(out_valid), 64'(1));
    check("t3_held_data", 64'(out_data), 64'(32'h44332211));
    out_ready = 1'b1;
    drain(40);
    repeat (3) tick();

    // Flush of a 3-word residue, then a flush with nothing pending.
    send(8'hA1);
    send(8'hB2);
    send(8'hC3);
    wait_popped(20);
    repeat (2) tick();
    fd0 = fd_cnt;
    flush_pulse();
    drain(20);
    wait_fd(fd0 + 1, 20);
    fd0 = fd_cnt;
    flush_pulse();
    repeat (10) tick();
    check("t4_empty_flush_done", 64'(fd_cnt), 64'(fd0 + 1));

    // Flush while the last pop is still in flight: that word must be included.
    send(8'h5A);
    send(8'h6B);
    wait_popped(20);
    fd0 = fd_cnt;
    flush_pulse();
    drain(20);
    wait_fd(fd0 + 1, 20);

    // Soft init with two lanes filled discards them.
    send(8'h01);
    send(8'h02);
    wait_popped(20);
    repeat (2) tick();
    init = 1'b1;
    #2;
    check("t6_fifo_init", 64'(fifo_init), 64'(1));
    check("t6_no_pop", 64'(fifo_rd_en), 64'(0));
    @(posedge clk);
    #1;
    init = 1'b0;
    cyc++;
    stall_prev = 1'b0;
    lanes.delete();
    check("t6_out_valid", 64'(out_valid), 64'(0));
    for (int i = 1; i <= 4; i++) send(DATA_W'(8'h60 + i));
    drain(30);

    // Random words, random back-pressure, occasional flushes.
    rand_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 11));
      for (int k = 0; k < n; k++) send(DATA_W'($urandom));
      wait_popped(300);
      repeat (2) tick();
      if ($urandom_range(0, 1) == 1) begin
        fd0 = fd_cnt;
        flush_pulse();
        wait_fd(fd0 + 1, 300);
      end
    end
    fd0 = fd_cnt;
    flush_pulse();
    wait_fd(fd0 + 1, 300);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain(300);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
